// File: rtl/kmap_sweeper_pkg.sv
// Shared types and constants for the K-map truth-table sweeper.
package kmap_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [15:0] KMAP_GOLDEN = 16'h6545;
  localparam int unsigned MINTERMS    = 16;
  localparam logic [3:0]  LAST_IDX    = 4'(MINTERMS - 1);

  // High when the sampled output disagrees with the golden table at this minterm.
  function automatic logic bit_differs(input logic [15:0] golden,
                                       input logic [3:0]  idx,
                                       input logic        f);
    return golden[idx] ^ f;
  endfunction

endpackage

// File: rtl/kmap_sweeper_if.sv
// Handshake/result bundle between the sweeper and the K-map under test.
interface kmap_sweeper_if;

  logic        start;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        f;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic        match;
  logic [4:0]  mismatch_cnt;

  modport master (
    input  start,
    input  f,
    output a,
    output b,
    output c,
    output d,
    output busy,
    output done,
    output table_out,
    output match,
    output mismatch_cnt
  );

  modport slave (
    output start,
    output f,
    input  a,
    input  b,
    input  c,
    input  d,
    input  busy,
    input  done,
    input  table_out,
    input  match,
    input  mismatch_cnt
  );

endinterface

// File: rtl/kmap_sweeper_settle_timer.sv
// Loadable down-counter that times how long each minterm is held before sampling.
module kmap_sweeper_settle_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load has priority; decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/kmap_sweeper.sv
// Walks minterms 0..15 through an attached K-map, captures f into a truth table
// and compares it against a golden constant.
module kmap_sweeper
  import kmap_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE   = 1,
  parameter logic [15:0] EXPECTED = KMAP_GOLDEN
) (
  input  logic           clk,
  input  logic           rst,
  kmap_sweeper_if.master bus
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_SAMPLE = SAMPLE;
  localparam logic [1:0] S_DONE   = DONE;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  logic [1:0]  state_q,    state_d;
  logic [3:0]  idx_q,      idx_d;
  logic [15:0] work_tbl_q, work_tbl_d;
  logic [4:0]  work_cnt_q, work_cnt_d;
  logic [3:0]  abcd_q,     abcd_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;
  logic [15:0] table_q,    table_d;
  logic        match_q,    match_d;
  logic [4:0]  mcnt_q,     mcnt_d;

  logic        load_s;
  logic        dec_s;
  logic        zero_s;

  kmap_sweeper_settle_timer #(
    .W (4)
  ) u_settle_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load_s),
    .load_val_i (SETTLE_LOAD),
    .dec_i      (dec_s),
    .zero_o     (zero_s)
  );

  // Sequencer next-state, working table capture and result publication.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    work_tbl_d = work_tbl_q;
    work_cnt_d = work_cnt_q;
    table_d    = table_q;
    match_d    = match_q;
    mcnt_d     = mcnt_q;
    load_s     = 1'b0;
    dec_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d      = 4'd0;
          load_s     = 1'b1;
          work_tbl_d = 16'h0000;
          work_cnt_d = 5'd0;
          state_d    = S_WAIT;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_WAIT: begin
        if (zero_s) begin
          state_d = S_SAMPLE;
        end else begin
          dec_s   = 1'b1;
        end
      end
      S_SAMPLE: begin
        work_tbl_d[idx_q] = bus.f;
        work_cnt_d        = work_cnt_q + {4'd0, bit_differs(EXPECTED, idx_q, bus.f)};
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          load_s  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        table_d = work_tbl_q;
        mcnt_d  = work_cnt_q;
        match_d = (work_cnt_q == 5'd0);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    abcd_d = (state_d == S_IDLE) ? 4'd0 : idx_d;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      work_tbl_q <= 16'h0000;
      work_cnt_q <= 5'd0;
      abcd_q     <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      table_q    <= 16'h0000;
      match_q    <= 1'b0;
      mcnt_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      work_tbl_q <= work_tbl_d;
      work_cnt_q <= work_cnt_d;
      abcd_q     <= abcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      table_q    <= table_d;
      match_q    <= match_d;
      mcnt_q     <= mcnt_d;
    end
  end

  assign bus.a            = abcd_q[3];
  assign bus.b            = abcd_q[2];
  assign bus.c            = abcd_q[1];
  assign bus.d            = abcd_q[0];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_out    = table_q;
  assign bus.match        = match_q;
  assign bus.mismatch_cnt = mcnt_q;

endmodule
